// File: rtl/link_test_master.sv
// Serial self-test link initiator/checker: sends framed LFSR words, checks the returned frames.
// Optional `LINK_TEST_INJECT_EN adds inject_err to corrupt bit 0 of transmitted words.
module link_test_master #(
  parameter int unsigned WORDS   = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] SEED    = 32'hA5A5_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef LINK_TEST_INJECT_EN
  input  logic        inject_err,
`endif
  input  logic        ser_in,
  output logic        ser_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt
);

  localparam int unsigned WC_W  = $clog2(WORDS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_RX_WAIT, S_RX, S_CMP, S_NEXT, S_DONE
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q;
  logic [31:0]       tx_lfsr_q, exp_lfsr_q, rx_sh_q;
  logic [5:0]        tx_cnt_q;
  logic [4:0]        rx_cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic              inject_q;
  logic              ser_out_q, busy_q, done_q, pass_q;
  logic [15:0]       err_q;

  logic [31:0]       tx_lfsr_d, exp_lfsr_d;
  logic [15:0]       err_inc_d;
  logic [WC_W-1:0]   word_cnt_d;
  logic              tx_bit_d;
  logic              inject_w;

`ifdef LINK_TEST_INJECT_EN
  assign inject_w = inject_err;
`else
  assign inject_w = 1'b0;
`endif

  assign tx_lfsr_d  = lfsr_step(tx_lfsr_q);
  assign exp_lfsr_d = lfsr_step(exp_lfsr_q);
  assign err_inc_d  = sat_inc(err_q);
  assign word_cnt_d = word_cnt_q + 1'b1;
  // Count 0..31 selects bit 31..0; the injected flip lands on the last data bit only.
  assign tx_bit_d   = tx_lfsr_q[~tx_cnt_q[4:0]] ^ ((tx_cnt_q[4:0] == 5'd31) & inject_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_lfsr_q  <= SEED;
      exp_lfsr_q <= SEED;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tmr_q      <= '0;
      word_cnt_q <= '0;
      inject_q   <= 1'b0;
      ser_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q      <= '0;
            pass_q     <= 1'b0;
            tx_lfsr_q  <= SEED;
            exp_lfsr_q <= SEED;
            busy_q     <= 1'b1;
            ser_out_q  <= 1'b1;
            tx_cnt_q   <= '0;
            word_cnt_q <= '0;
            state_q    <= S_TX;
          end
        end
        S_TX: begin
          if (tx_cnt_q == 6'd32) begin
            ser_out_q <= 1'b0;
            tx_lfsr_q <= tx_lfsr_d;
            tmr_q     <= '0;
            state_q   <= S_RX_WAIT;
          end else begin
            if (tx_cnt_q == 6'd0) inject_q <= inject_w;
            ser_out_q <= tx_bit_d;
            tx_cnt_q  <= tx_cnt_q + 6'd1;
          end
        end
        S_RX_WAIT: begin
          if (ser_in) begin
            rx_cnt_q <= '0;
            state_q  <= S_RX;
          end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            err_q      <= err_inc_d;
            exp_lfsr_q <= exp_lfsr_d;
            state_q    <= S_NEXT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_RX: begin
          rx_cnt_q <= rx_cnt_q + 5'd1;
          if (rx_cnt_q == 5'd31) state_q <= S_CMP;
        end
        S_CMP: begin
          if (rx_sh_q != exp_lfsr_q) err_q <= err_inc_d;
          exp_lfsr_q <= exp_lfsr_d;
          state_q    <= S_NEXT;
        end
        S_NEXT: begin
          word_cnt_q <= word_cnt_d;
          if (word_cnt_d == WC_W'(WORDS)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_q == '0);
            state_q <= S_DONE;
          end else begin
            ser_out_q <= 1'b1;
            tx_cnt_q  <= '0;
            state_q   <= S_TX;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Receive shift register: pure datapath, only shifts while in RX.
  always_ff @(posedge clk) begin
    if (state_q == S_RX) rx_sh_q <= {rx_sh_q[30:0], ser_in};
  end

  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_link_test_master.sv
// Scoreboard bench for link_test_master: a frame-echo model returns each transmitted word.
module tb_link_test_master;

  localparam int unsigned WORDS   = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [31:0] SEED    = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ser_in;
  logic        ser_out, busy, done, pass;
  logic [15:0] err_cnt;
`ifdef LINK_TEST_INJECT_EN
  logic        inject_err = 1'b0;
`endif

  link_test_master #(.WORDS(WORDS), .TIMEOUT(TIMEOUT), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef LINK_TEST_INJECT_EN
    .inject_err(inject_err),
`endif
    .ser_in(ser_in), .ser_out(ser_out), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Far-side echo model: captures a full frame, waits, then replays it (optionally corrupted).
  logic        echo_en = 1'b0;
  int          ephase = 0;
  int          ecnt = 0;
  int          edelay = 3;
  int          eword = 0;
  int          flip_word = -1;
  logic [31:0] flip_mask = 32'h0;
  logic [31:0] cap = 32'h0;
  logic [31:0] ew;

  always @(negedge clk) begin
    if (!echo_en) begin
      ephase = 0;
      ser_in = 1'b0;
    end else begin
      case (ephase)
        0: begin
          ser_in = 1'b0;
          if (ser_out) begin ephase = 1; ecnt = 0; end
        end
        1: begin
          cap = {cap[30:0], ser_out};
          ecnt++;
          if (ecnt == 32) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL frame_unexpected: got %08h, no word expected", cap);
            end else begin
              ew = exp_q.pop_front();
              if (cap !== ew) begin
                n_err++;
                $display("FAIL frame_word%0d: got %08h expected %08h", eword, cap, ew);
              end
            end
            if (eword == flip_word) cap = cap ^ flip_mask;
            eword++;
            ephase = 2;
            ecnt = 0;
          end
        end
        2: begin
          if (ecnt == edelay) begin ser_in = 1'b1; ephase = 3; ecnt = 0; end
          else ecnt++;
        end
        3: begin
          ser_in = cap[31 - ecnt];
          ecnt++;
          if (ecnt == 32) ephase = 4;
        end
        default: begin
          ser_in = 1'b0;
          ephase = 0;
        end
      endcase
    end
  end

  function automatic logic [31:0] lfsr_nxt(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  task automatic push_words(input logic [31:0] xmask);
    logic [31:0] w;
    w = SEED;
    exp_q.delete();
    for (int i = 0; i < int'(WORDS); i++) begin
      exp_q.push_back(w ^ xmask);
      w = lfsr_nxt(w);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ser_out, busy, done, pass, err_cnt} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got so=%b busy=%b done=%b pass=%b err=%0d required all 0",
               ser_out, busy, done, pass, err_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ser_out, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got so=%b busy=%b required 0 0", ser_out, busy);
    end
  endtask

  task automatic test_loopback();
    int cyc;
    echo_en = 1'b1; eword = 0; flip_word = -1; flip_mask = 32'h0;
    push_words(32'h0);
    pulse_start();
    n_cmp++;
    if ({busy, ser_out} !== 2'b11) begin
      n_err++;
      $display("FAIL first_tx_cycle: got busy=%b so=%b required 1 1", busy, ser_out);
    end
    wait_done(2000, cyc);
    n_cmp++;
    if (cyc !== 4 * 71) begin
      n_err++;
      $display("FAIL loop_run_cycles: got %0d required %0d", cyc, 4 * 71);
    end
    n_cmp++;
    if ({done, busy, pass, err_cnt} !== {3'b101, 16'd0}) begin
      n_err++;
      $display("FAIL loop_result: got done=%b busy=%b pass=%b err=%0d required 1 0 1 0",
               done, busy, pass, err_cnt);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL loop_words_left: got %0d required 0", exp_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if ({done, pass} !== 2'b01) begin
      n_err++;
      $display("FAIL done_pulse_hold: got done=%b pass=%b required 0 1", done, pass);
    end
  endtask

  task automatic test_bitflip();
    int cyc;
    echo_en = 1'b1; eword = 0; flip_word = 2; flip_mask = 32'h0000_0020;
    push_words(32'h0);
    pulse_start();
    wait_done(2000, cyc);
    n_cmp++;
    if ({done, pass, err_cnt} !== {2'b10, 16'd1}) begin
      n_err++;
      $display("FAIL flip_result: got done=%b pass=%b err=%0d required 1 0 1", done, pass, err_cnt);
    end
    flip_word = -1; flip_mask = 32'h0;
  endtask

  task automatic test_timeout();
    int cyc;
    echo_en = 1'b0;
    pulse_start();
    wait_done(3000, cyc);
    n_cmp++;
    if (cyc !== 4 * (33 + 255 + 1)) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d required %0d", cyc, 4 * (33 + 255 + 1));
    end
    n_cmp++;
    if ({done, pass, err_cnt} !== {2'b10, 16'd4}) begin
      n_err++;
      $display("FAIL timeout_result: got done=%b pass=%b err=%0d required 1 0 4", done, pass, err_cnt);
    end
  endtask

  task automatic test_start_mid_run();
    int cyc;
    echo_en = 1'b1; eword = 0;
    push_words(32'h0);
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_busy: got %b required 1", busy);
    end
    wait_done(2000, cyc);
    n_cmp++;
    if (cyc + 101 !== 4 * 71) begin
      n_err++;
      $display("FAIL restart_cycles: got %0d required %0d", cyc + 101, 4 * 71);
    end
    n_cmp++;
    if ({done, pass, err_cnt, exp_q.size() == 0} !== {2'b11, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL restart_result: got done=%b pass=%b err=%0d left=%0d required 1 1 0 0",
               done, pass, err_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    echo_en = 1'b0;
    pulse_start();
    repeat (299) @(negedge clk);
    n_cmp++;
    if ({busy, err_cnt} !== {1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL pre_rst_state: got busy=%b err=%0d required 1 1", busy, err_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ser_out, busy, done, err_cnt} !== 19'h0) begin
      n_err++;
      $display("FAIL rst_mid_tx: got so=%b busy=%b done=%b err=%0d required all 0",
               ser_out, busy, done, err_cnt);
    end
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ser_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL post_rst_idle: got %0d active cycles required 0", bad);
    end
  endtask

`ifdef LINK_TEST_INJECT_EN
  task automatic test_inject();
    int cyc;
    echo_en = 1'b1; eword = 0;
    inject_err = 1'b1;
    push_words(32'h0000_0001);
    pulse_start();
    wait_done(2000, cyc);
    n_cmp++;
    if ({done, pass, err_cnt} !== {2'b10, 16'd4}) begin
      n_err++;
      $display("FAIL inject_on: got done=%b pass=%b err=%0d required 1 0 4", done, pass, err_cnt);
    end
    inject_err = 1'b0;
    eword = 0;
    push_words(32'h0);
    pulse_start();
    wait_done(2000, cyc);
    n_cmp++;
    if ({done, pass, err_cnt} !== {2'b11, 16'd0}) begin
      n_err++;
      $display("FAIL inject_off: got done=%b pass=%b err=%0d required 1 1 0", done, pass, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_bitflip();
    test_timeout();
    test_start_mid_run();
`ifdef LINK_TEST_INJECT_EN
    test_inject();
`endif
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
